// File: rtl/sodor5_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sodor5_chk_pkg
// Description : Shared types and constants for the writeback commit checker.
// Revision    : 1.0 - initial release
// ============================================================================
package sodor5_chk_pkg;

    localparam int WORD_SIZE = 32;
    localparam int NUM_REGS  = 32;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        ERR = 1'b1
    } chk_state_e;

    typedef struct packed {
        logic [4:0]           rd;
        logic [WORD_SIZE-1:0] data;
    } wb_event_t;

endpackage
`default_nettype wire

// File: rtl/chk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : chk_fifo
// Description : Synchronous FIFO of writeback events; head is registered
//               storage only, so a push is visible one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module chk_fifo import sodor5_chk_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_event_t i_push_data,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wb_event_t o_head
);

    localparam int                  c_addr_w   = $clog2(DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_one  = c_addr_w'(1);
    localparam logic [c_addr_w:0]   c_cnt_one  = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w:0]   c_cnt_full = (c_addr_w + 1)'(DEPTH);

    wb_event_t             r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == c_cnt_full);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wb_commit_checker.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_checker
// Description : Pairs model and core writeback events in order, counts
//               matches and latches the first mismatch/overflow/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_checker import sodor5_chk_pkg::*; #(
    parameter int WORD_SIZE = sodor5_chk_pkg::WORD_SIZE,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 model_wb_valid,
    input  logic [4:0]           model_wb_rd,
    input  logic [WORD_SIZE-1:0] model_wb_data,
    input  logic                 core_wb_valid,
    input  logic [4:0]           core_wb_rd,
    input  logic [WORD_SIZE-1:0] core_wb_data,
    output logic [31:0]          match_count,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [4:0]           err_model_rd,
    output logic [WORD_SIZE-1:0] err_model_data,
    output logic [4:0]           err_core_rd,
    output logic [WORD_SIZE-1:0] err_core_data,
    output logic                 idle
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    chk_state_e           r_state;
    chk_state_e           w_next_state;
    logic                 w_run;

    wb_event_t            w_model_in, w_core_in;
    wb_event_t            w_model_head, w_core_head;
    logic                 w_model_full, w_model_empty;
    logic                 w_core_full, w_core_empty;
    logic                 w_model_req, w_core_req;
    logic                 w_model_ovf, w_core_ovf;
    logic                 w_model_push, w_core_push;
    logic                 w_pop, w_mismatch, w_one_pending, w_timeout;
    logic [1:0]           w_err_code;

    logic [c_cnt_w-1:0]   r_to_cnt;
    logic [31:0]          r_match_count;
    logic [1:0]           r_error_code;
    logic [4:0]           r_err_model_rd, r_err_core_rd;
    logic [WORD_SIZE-1:0] r_err_model_data, r_err_core_data;

    assign w_model_in = '{rd: model_wb_rd, data: model_wb_data};
    assign w_core_in  = '{rd: core_wb_rd,  data: core_wb_data};

    // Writes to x0 never retire architecturally, so they are dropped here.
    assign w_model_req   = w_run && model_wb_valid && (model_wb_rd != 5'd0);
    assign w_core_req    = w_run && core_wb_valid  && (core_wb_rd  != 5'd0);
    assign w_pop         = w_run && !w_model_empty && !w_core_empty;
    assign w_model_ovf   = w_model_req && w_model_full && !w_pop;
    assign w_core_ovf    = w_core_req  && w_core_full  && !w_pop;
    assign w_model_push  = w_model_req && !w_model_ovf;
    assign w_core_push   = w_core_req  && !w_core_ovf;
    assign w_mismatch    = w_pop && (w_model_head != w_core_head);
    assign w_one_pending = w_run && (w_model_empty != w_core_empty);
    assign w_timeout     = w_one_pending && (r_to_cnt == c_to_last);

    always_comb begin
        w_err_code = ERR_NONE;
        if (w_model_ovf || w_core_ovf) begin
            w_err_code = ERR_OVERFLOW;
        end else if (w_mismatch) begin
            w_err_code = ERR_MISMATCH;
        end else if (w_timeout) begin
            w_err_code = ERR_TIMEOUT;
        end
    end

    chk_fifo #(.DEPTH(DEPTH)) u_model_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_model_push),
        .i_push_data (w_model_in),
        .i_pop       (w_pop),
        .o_full      (w_model_full),
        .o_empty     (w_model_empty),
        .o_head      (w_model_head)
    );

    chk_fifo #(.DEPTH(DEPTH)) u_core_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_core_push),
        .i_push_data (w_core_in),
        .i_pop       (w_pop),
        .o_full      (w_core_full),
        .o_empty     (w_core_empty),
        .o_head      (w_core_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (w_err_code != ERR_NONE) w_next_state = ERR;
            default: w_next_state = ERR;
        endcase
    end

    always_comb begin
        w_run = 1'b0;
        error = 1'b0;
        if (r_state == RUN) begin
            w_run = 1'b1;
        end else begin
            error = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_run) begin
            if (w_pop || (w_model_empty && w_core_empty)) begin
                r_to_cnt <= '0;
            end else if (w_one_pending) begin
                r_to_cnt <= r_to_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_count <= '0;
        end else if (w_pop && !w_mismatch) begin
            r_match_count <= r_match_count + 32'd1;
        end
    end

    // Error sources are all gated by RUN, so the capture freezes in ERR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error_code     <= ERR_NONE;
            r_err_model_rd   <= '0;
            r_err_model_data <= '0;
            r_err_core_rd    <= '0;
            r_err_core_data  <= '0;
        end else if (w_err_code != ERR_NONE) begin
            r_error_code <= w_err_code;
            case (w_err_code)
                ERR_OVERFLOW: begin
                    r_err_model_rd   <= w_model_ovf ? model_wb_rd   : 5'd0;
                    r_err_model_data <= w_model_ovf ? model_wb_data : '0;
                    r_err_core_rd    <= w_core_ovf  ? core_wb_rd    : 5'd0;
                    r_err_core_data  <= w_core_ovf  ? core_wb_data  : '0;
                end
                ERR_MISMATCH: begin
                    r_err_model_rd   <= w_model_head.rd;
                    r_err_model_data <= w_model_head.data;
                    r_err_core_rd    <= w_core_head.rd;
                    r_err_core_data  <= w_core_head.data;
                end
                default: begin
                    r_err_model_rd   <= w_model_empty ? 5'd0 : w_model_head.rd;
                    r_err_model_data <= w_model_empty ? '0   : w_model_head.data;
                    r_err_core_rd    <= w_core_empty  ? 5'd0 : w_core_head.rd;
                    r_err_core_data  <= w_core_empty  ? '0   : w_core_head.data;
                end
            endcase
        end
    end

    assign match_count    = r_match_count;
    assign error_code     = r_error_code;
    assign err_model_rd   = r_err_model_rd;
    assign err_model_data = r_err_model_data;
    assign err_core_rd    = r_err_core_rd;
    assign err_core_data  = r_err_core_data;
    assign idle           = w_model_empty && w_core_empty;

endmodule
`default_nettype wire
